// File: rtl/mem_ls_ctrl_pkg.sv
// Shared load/store definitions: selector codes, FSM states, bus size codes
// and small decode helpers used by the controller and its formatter.
package mem_ls_ctrl_pkg;

    typedef enum logic [3:0] {
        SEL_NOP = 4'd0,
        SEL_LB  = 4'd1,
        SEL_LBU = 4'd2,
        SEL_LH  = 4'd3,
        SEL_LHU = 4'd4,
        SEL_LW  = 4'd5,
        SEL_SB  = 4'd6,
        SEL_SH  = 4'd7,
        SEL_SW  = 4'd8
    } ls_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_DONE   = 3'd3,
        ST_CANCEL = 3'd4
    } ls_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic sel_is_load(input logic [3:0] sel);
        return (sel >= SEL_LB) && (sel <= SEL_LW);
    endfunction

    function automatic logic sel_is_store(input logic [3:0] sel);
        return (sel >= SEL_SB) && (sel <= SEL_SW);
    endfunction

    function automatic logic [1:0] sel_size(input logic [3:0] sel);
        logic [1:0] size;
        case (ls_sel_e'(sel))
            SEL_LB, SEL_LBU, SEL_SB: size = SIZE_BYTE;
            SEL_LH, SEL_LHU, SEL_SH: size = SIZE_HALF;
            SEL_LW, SEL_SW:          size = SIZE_WORD;
            default:                 size = SIZE_BYTE;
        endcase
        return size;
    endfunction

    // Halves need addr[0] clear, words need addr[1:0] clear; bytes and
    // unknown selectors never fault.
    function automatic logic sel_misaligned(input logic [3:0] sel, input logic [1:0] lo);
        logic bad;
        case (ls_sel_e'(sel))
            SEL_LH, SEL_LHU, SEL_SH: bad = lo[0];
            SEL_LW, SEL_SW:          bad = |lo;
            default:                 bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_ls_ctrl_fmt.sv
// ls_data_fmt: store-side byte-lane replication and strobes, load-side lane
// selection with sign/zero extension. Purely combinational.
module ls_data_fmt
    import mem_ls_ctrl_pkg::*;
(
    input  logic [3:0]  st_sel,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_rt,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [3:0]  ld_sel,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Replicate store data across the lanes and strobe the addressed ones.
    always_comb begin
        case (ls_sel_e'(st_sel))
            SEL_SB: begin
                st_wdata = {4{st_rt[7:0]}};
                st_wstrb = 4'b0001 << st_addr_lo;
            end
            SEL_SH: begin
                st_wdata = {2{st_rt[15:0]}};
                st_wstrb = 4'b0011 << st_addr_lo;
            end
            SEL_SW: begin
                st_wdata = st_rt;
                st_wstrb = 4'hF;
            end
            default: begin
                st_wdata = 32'd0;
                st_wstrb = 4'h0;
            end
        endcase
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        case (ld_addr_lo)
            2'd0:    ld_byte_s = ld_rdata[7:0];
            2'd1:    ld_byte_s = ld_rdata[15:8];
            2'd2:    ld_byte_s = ld_rdata[23:16];
            2'd3:    ld_byte_s = ld_rdata[31:24];
            default: ld_byte_s = 8'd0;
        endcase
        if (ld_addr_lo[1]) begin
            ld_half_s = ld_rdata[31:16];
        end else begin
            ld_half_s = ld_rdata[15:0];
        end
        case (ls_sel_e'(ld_sel))
            SEL_LB:  ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
            SEL_LBU: ld_data = {24'd0, ld_byte_s};
            SEL_LH:  ld_data = {{16{ld_half_s[15]}}, ld_half_s};
            SEL_LHU: ld_data = {16'd0, ld_half_s};
            SEL_LW:  ld_data = ld_rdata;
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_ls_ctrl.sv
// Load/store request controller between EX and the data bus. Issues one
// transaction at a time, holds EX while it is outstanding, absorbs responses
// of flushed requests and registers the extended load result for MEM.
module mem_ls_ctrl
    import mem_ls_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_ls_ena,
    input  logic [3:0]  ex_ls_sel,
    input  logic [31:0] ex_ls_addr,
    input  logic [31:0] ex_rt_data,
    input  logic        ex_has_exception,
    input  logic        flush,
    input  logic        pipe_stall,
    output logic        to_ex_is_data_adel,
    output logic        to_ex_is_data_ades,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        ls_stall_req,
    output logic [31:0] mem_load_data
);

    ls_state_e   state_r;
    logic        flush_seen_r;
    logic [3:0]  sel_r;
    logic [31:0] addr_r;
    logic [1:0]  size_r;
    logic        wr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic [31:0] load_data_r;

    logic        is_load_s;
    logic        is_store_s;
    logic        misal_s;
    logic        eligible_s;
    logic        can_issue_s;
    logic        issue_s;
    logic [31:0] st_wdata_s;
    logic [3:0]  st_wstrb_s;
    logic [31:0] ld_data_s;

    ls_data_fmt u_fmt (
        .st_sel     (ex_ls_sel),
        .st_addr_lo (ex_ls_addr[1:0]),
        .st_rt      (ex_rt_data),
        .st_wdata   (st_wdata_s),
        .st_wstrb   (st_wstrb_s),
        .ld_sel     (sel_r),
        .ld_addr_lo (addr_r[1:0]),
        .ld_rdata   (data_rdata),
        .ld_data    (ld_data_s)
    );

    // Decode the EX request: alignment faults and whether it may issue now.
    // Issue is held off while reset is asserted so the bus reads all-zero.
    always_comb begin
        is_load_s          = sel_is_load(ex_ls_sel);
        is_store_s         = sel_is_store(ex_ls_sel);
        misal_s            = sel_misaligned(ex_ls_sel, ex_ls_addr[1:0]);
        to_ex_is_data_adel = ex_ls_ena & is_load_s & misal_s;
        to_ex_is_data_ades = ex_ls_ena & is_store_s & misal_s;
        eligible_s         = ex_ls_ena & ~ex_has_exception & ~misal_s & ~flush
                             & (is_load_s | is_store_s);
        can_issue_s        = (state_r == ST_IDLE) | ((state_r == ST_DONE) & ~pipe_stall);
        issue_s            = eligible_s & can_issue_s & rst;
    end

    // Bus fields: live EX values in the issue cycle, latched values afterwards.
    always_comb begin
        if (issue_s) begin
            data_wr    = is_store_s;
            data_size  = sel_size(ex_ls_sel);
            data_addr  = ex_ls_addr;
            data_wdata = st_wdata_s;
            data_wstrb = st_wstrb_s;
        end else begin
            data_wr    = wr_r;
            data_size  = size_r;
            data_addr  = addr_r;
            data_wdata = wdata_r;
            data_wstrb = wstrb_r;
        end
        data_req      = issue_s | (state_r == ST_ADDR);
        mem_load_data = load_data_r;
    end

    // Hold EX while a transaction for it (or a cancelled one) is in flight.
    always_comb begin
        case (state_r)
            ST_IDLE, ST_DONE: ls_stall_req = issue_s & ~data_data_ok;
            ST_ADDR:          ls_stall_req = 1'b1;
            ST_DATA:          ls_stall_req = ~data_data_ok;
            ST_CANCEL:        ls_stall_req = ex_ls_ena;
            default:          ls_stall_req = 1'b0;
        endcase
    end

    // Transaction FSM, request latch, flush-sticky bit and load result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            flush_seen_r <= 1'b0;
            sel_r        <= 4'd0;
            addr_r       <= 32'd0;
            size_r       <= 2'd0;
            wr_r         <= 1'b0;
            wdata_r      <= 32'd0;
            wstrb_r      <= 4'h0;
            load_data_r  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (issue_s) begin
                        sel_r        <= ex_ls_sel;
                        addr_r       <= ex_ls_addr;
                        size_r       <= sel_size(ex_ls_sel);
                        wr_r         <= is_store_s;
                        wdata_r      <= st_wdata_s;
                        wstrb_r      <= st_wstrb_s;
                        flush_seen_r <= 1'b0;
                        state_r      <= data_addr_ok ? ST_DATA : ST_ADDR;
                    end else if ((state_r == ST_DONE) && pipe_stall) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    // The request stays up until accepted; a flush only marks it.
                    if (data_addr_ok) begin
                        state_r      <= (flush_seen_r | flush) ? ST_CANCEL : ST_DATA;
                        flush_seen_r <= 1'b0;
                    end else if (flush) begin
                        flush_seen_r <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (flush) begin
                        state_r <= data_data_ok ? ST_IDLE : ST_CANCEL;
                    end else if (data_data_ok) begin
                        state_r <= ST_DONE;
                        if (sel_is_load(sel_r)) begin
                            load_data_r <= ld_data_s;
                        end
                    end
                end
                ST_CANCEL: begin
                    if (data_data_ok) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ls_ctrl.sv
// Self-checking bench for mem_ls_ctrl: directed scenarios followed by
// randomized transactions checked against a transaction-level model.
module tb_mem_ls_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_ls_ena;
    logic [3:0]  ex_ls_sel;
    logic [31:0] ex_ls_addr;
    logic [31:0] ex_rt_data;
    logic        ex_has_exception;
    logic        flush;
    logic        pipe_stall;
    logic        to_ex_is_data_adel;
    logic        to_ex_is_data_ades;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        ls_stall_req;
    logic [31:0] mem_load_data;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;
    logic [31:0] exp_load = 32'd0;

    always #5 clk = ~clk;

    mem_ls_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .ex_ls_ena          (ex_ls_ena),
        .ex_ls_sel          (ex_ls_sel),
        .ex_ls_addr         (ex_ls_addr),
        .ex_rt_data         (ex_rt_data),
        .ex_has_exception   (ex_has_exception),
        .flush              (flush),
        .pipe_stall         (pipe_stall),
        .to_ex_is_data_adel (to_ex_is_data_adel),
        .to_ex_is_data_ades (to_ex_is_data_ades),
        .data_req           (data_req),
        .data_wr            (data_wr),
        .data_size          (data_size),
        .data_addr          (data_addr),
        .data_wdata         (data_wdata),
        .data_wstrb         (data_wstrb),
        .data_addr_ok       (data_addr_ok),
        .data_data_ok       (data_data_ok),
        .data_rdata         (data_rdata),
        .ls_stall_req       (ls_stall_req),
        .mem_load_data      (mem_load_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- reference model (selector numbering: 1..5 loads, 6..8 stores) ----
    function automatic int op_bytes(input int sel);
        if (sel == 1 || sel == 2 || sel == 6) return 1;
        if (sel == 3 || sel == 4 || sel == 7) return 2;
        if (sel == 5 || sel == 8) return 4;
        return 0;
    endfunction

    function automatic bit op_load(input int sel);
        return sel >= 1 && sel <= 5;
    endfunction

    function automatic bit op_store(input int sel);
        return sel >= 6 && sel <= 8;
    endfunction

    function automatic logic [31:0] exp_wdata(input int sel, input logic [31:0] rt);
        if (sel == 6) return (rt % 256) * 32'h0101_0101;
        if (sel == 7) return (rt % 65536) * 32'h0001_0001;
        if (sel == 8) return rt;
        return 32'd0;
    endfunction

    function automatic logic [3:0] exp_wstrb(input int sel, input logic [31:0] addr);
        int v;
        if (!op_store(sel)) return 4'h0;
        v = ((1 << op_bytes(sel)) - 1) << (addr % 4);
        return 4'(v);
    endfunction

    function automatic logic [1:0] exp_size(input int sel);
        int n;
        n = op_bytes(sel);
        if (n == 2) return 2'd1;
        if (n == 4) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] exp_ext(input int sel, input logic [31:0] addr, input logic [31:0] rdata);
        int unsigned off, b, h;
        off = addr % 4;
        b = (rdata >> (8 * off)) % 256;
        h = (rdata >> (8 * off)) % 65536;
        case (sel)
            1:       return (b >= 128) ? 32'(int'(b) - 256) : b;
            2:       return b;
            3:       return (h >= 32768) ? 32'(int'(h) - 65536) : h;
            4:       return h;
            default: return rdata;
        endcase
    endfunction

    // One EX load/store from the issue cycle through completion or cancel.
    // fl_mode: 0 none, 1 flush in ADDR cycle fl_at, 2 flush in DATA cycle fl_at.
    task automatic run_op(input bit ena, input int sel, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [31:0] rdata,
                          input bit exc, input bit fl_issue, input int a_dly,
                          input int d_dly, input int fl_mode, input int fl_at,
                          input int hold, input bit b2b);
        bit elig, misal, cancelled, ended_done;
        int n, nit;
        n     = op_bytes(sel);
        misal = (n > 1) && ((addr % n) != 0);
        elig  = ena && !exc && !fl_issue && !misal && (op_load(sel) || op_store(sel));

        ex_ls_ena        = ena;
        ex_ls_sel        = 4'(sel);
        ex_ls_addr       = addr;
        ex_rt_data       = rt;
        ex_has_exception = exc;
        flush            = fl_issue;
        pipe_stall       = 1'b0;
        data_addr_ok     = elig && (a_dly == 0);
        data_data_ok     = 1'b0;
        #2;
        chk("adel", to_ex_is_data_adel, ena && op_load(sel) && misal);
        chk("ades", to_ex_is_data_ades, ena && op_store(sel) && misal);
        chk("issue_req", data_req, elig);
        chk("issue_stall", ls_stall_req, elig);
        chk("pre_load", mem_load_data, exp_load);
        if (elig) begin
            chk("issue_addr", data_addr, addr);
            chk("issue_wr", data_wr, op_store(sel));
            chk("issue_size", data_size, exp_size(sel));
            chk("issue_wdata", data_wdata, exp_wdata(sel, rt));
            chk("issue_wstrb", data_wstrb, exp_wstrb(sel, addr));
        end
        tick();
        flush        = 1'b0;
        data_addr_ok = 1'b0;
        if (!elig) begin
            ex_ls_ena        = 1'b0;
            ex_has_exception = 1'b0;
            return;
        end

        cancelled = 1'b0;
        for (int k = 1; k <= a_dly; k++) begin
            data_addr_ok = (k == a_dly);
            if (fl_mode == 1 && k == fl_at) flush = 1'b1;
            #2;
            chk("addr_req", data_req, 1'b1);
            chk("addr_hold", data_addr, addr);
            chk("addr_wdata", data_wdata, exp_wdata(sel, rt));
            chk("addr_wstrb", data_wstrb, exp_wstrb(sel, addr));
            chk("addr_stall", ls_stall_req, 1'b1);
            tick();
            data_addr_ok = 1'b0;
            if (flush) begin
                flush      = 1'b0;
                cancelled  = 1'b1;
                ex_ls_ena  = 1'b0;
                ex_ls_addr = $urandom;
                ex_rt_data = $urandom;
                ex_ls_sel  = 4'($urandom_range(0, 15));
            end
        end

        for (int j = 1; j <= d_dly; j++) begin
            data_data_ok = (j == d_dly);
            data_rdata   = (j == d_dly) ? rdata : $urandom;
            if (cancelled) begin
                ex_ls_ena        = 1'($urandom_range(0, 1));
                ex_ls_sel        = 4'd5;
                ex_ls_addr       = $urandom & 32'hFFFF_FFFC;
                ex_has_exception = 1'b0;
                #2;
                chk("cancel_req", data_req, 1'b0);
                chk("cancel_stall", ls_stall_req, ex_ls_ena);
            end else begin
                if (fl_mode == 2 && j == fl_at) flush = 1'b1;
                #2;
                chk("data_req", data_req, 1'b0);
                chk("data_stall", ls_stall_req, j != d_dly);
            end
            tick();
            if (flush) begin
                flush     = 1'b0;
                cancelled = 1'b1;
                ex_ls_ena = 1'b0;
            end
        end
        data_data_ok     = 1'b0;
        data_rdata       = $urandom;
        ex_ls_ena        = 1'b0;
        ex_has_exception = 1'b0;

        ended_done = !cancelled;
        if (ended_done && op_load(sel)) exp_load = exp_ext(sel, addr, rdata);
        nit = ended_done ? hold + (b2b ? 0 : 1) : 1;
        for (int h = 0; h < nit; h++) begin
            pipe_stall = ended_done && (h < hold);
            ex_ls_ena  = pipe_stall;
            ex_ls_sel  = 4'd5;
            ex_ls_addr = $urandom & 32'hFFFF_FFFC;
            #2;
            chk("result", mem_load_data, exp_load);
            chk("post_req", data_req, 1'b0);
            chk("post_stall", ls_stall_req, 1'b0);
            tick();
        end
        pipe_stall = 1'b0;
        ex_ls_ena  = 1'b0;
    endtask

    initial begin
        rst              = 1'b0;
        ex_ls_ena        = 1'b0;
        ex_ls_sel        = 4'd0;
        ex_ls_addr       = 32'd0;
        ex_rt_data       = 32'd0;
        ex_has_exception = 1'b0;
        flush            = 1'b0;
        pipe_stall       = 1'b0;
        data_addr_ok     = 1'b0;
        data_data_ok     = 1'b0;
        data_rdata       = 32'd0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_req", data_req, 1'b0);
        chk("rst_wr", data_wr, 1'b0);
        chk("rst_size", data_size, 2'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_wdata", data_wdata, 32'd0);
        chk("rst_wstrb", data_wstrb, 4'h0);
        chk("rst_stall", ls_stall_req, 1'b0);
        chk("rst_load", mem_load_data, 32'd0);
        rst = 1'b1;
        tick();

        // Directed scenarios.
        run_op(1'b1, 5, 32'h1000, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1, 0, 0, 0, 1'b0);
        chk("lw_1000", mem_load_data, 32'hDEAD_BEEF);
        run_op(1'b1, 1, 32'h1003, 32'd0, 32'h80FF_FFFF, 1'b0, 1'b0, 1, 2, 0, 0, 1, 1'b0);
        chk("lb_1003", mem_load_data, 32'hFFFF_FF80);
        run_op(1'b1, 2, 32'h1003, 32'd0, 32'h80FF_FFFF, 1'b0, 1'b0, 0, 1, 0, 0, 0, 1'b0);
        chk("lbu_1003", mem_load_data, 32'h0000_0080);
        run_op(1'b1, 7, 32'h2002, 32'h1234_ABCD, 32'd0, 1'b0, 1'b0, 0, 1, 0, 0, 0, 1'b0);
        run_op(1'b1, 5, 32'h1002, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1, 0, 0, 0, 1'b0);
        run_op(1'b1, 7, 32'h2001, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1, 0, 0, 0, 1'b0);
        run_op(1'b1, 5, 32'h1004, 32'd0, 32'h55AA_55AA, 1'b0, 1'b0, 3, 2, 1, 2, 0, 1'b0);
        chk("flush_keeps", mem_load_data, 32'h0000_0080);

        // Reset while a load waits for its data.
        ex_ls_ena    = 1'b1;
        ex_ls_sel    = 4'd5;
        ex_ls_addr   = 32'h3000;
        data_addr_ok = 1'b1;
        #2;
        chk("rst_issue_req", data_req, 1'b1);
        tick();
        data_addr_ok = 1'b0;
        #2;
        chk("rst_data_stall", ls_stall_req, 1'b1);
        rst = 1'b0;
        #1;
        chk("arst_req", data_req, 1'b0);
        chk("arst_wr", data_wr, 1'b0);
        chk("arst_size", data_size, 2'd0);
        chk("arst_addr", data_addr, 32'd0);
        chk("arst_wdata", data_wdata, 32'd0);
        chk("arst_wstrb", data_wstrb, 4'h0);
        chk("arst_stall", ls_stall_req, 1'b0);
        chk("arst_load", mem_load_data, 32'd0);
        exp_load = 32'd0;
        tick();
        ex_ls_ena = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        run_op(1'b1, 5, 32'h3000, 32'd0, 32'h0BAD_F00D, 1'b0, 1'b0, 0, 1, 0, 0, 0, 1'b0);
        chk("lw_after_rst", mem_load_data, 32'h0BAD_F00D);

        // Randomized transactions.
        for (int t = 0; t < 250; t++) begin
            int sel, n, a_dly, d_dly, fm, fa;
            logic [31:0] addr;
            bit ena, exc, fi;
            sel   = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 8)) : int'($urandom_range(0, 15));
            n     = op_bytes(sel);
            addr  = $urandom;
            if (n > 1 && $urandom_range(0, 3) != 0) addr = addr - (addr % n);
            ena   = ($urandom_range(0, 19) != 0);
            exc   = ($urandom_range(0, 9) == 0);
            fi    = ($urandom_range(0, 19) == 0);
            a_dly = $urandom_range(0, 3);
            d_dly = $urandom_range(1, 3);
            fm    = $urandom_range(0, 6);
            fa    = 0;
            if (fm == 1 && a_dly > 0) begin
                fa = $urandom_range(1, a_dly);
            end else if (fm == 2) begin
                fa = $urandom_range(1, d_dly);
            end else begin
                fm = 0;
            end
            run_op(ena, sel, addr, $urandom, $urandom, exc, fi, a_dly, d_dly, fm, fa,
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_ls_ctrl.md
# mem_ls_ctrl

Load/store request controller between the EX stage and the data-side bus. It sits directly downstream of EX and consumes EX's load/store address, selector, store data and exception summary. It returns the address-error flags to EX and drives a request/address-ok/data-ok data bus. It holds the pipeline while a transaction is outstanding and presents the sign- or zero-extended load result to the MEM stage.

## Interface
Parameters:
- none. Load/store selector codes come from the shared definitions.

Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  reset. Asynchronous, active-low.
- `ex_ls_ena`  in  1  EX instruction is a load or store.
- `ex_ls_sel`  in  4  load/store selector code.
- `ex_ls_addr`  in  32  effective address.
- `ex_rt_data`  in  32  store data.
- `ex_has_exception`  in  1  EX instruction already carries an exception.
- `flush`  in  1  exception/eret flush of EX and older-than-MEM stages.
- `pipe_stall`  in  1  EX→MEM advance held by another stage.
- `to_ex_is_data_adel`  out  1  load alignment error (combinational).
- `to_ex_is_data_ades`  out  1  store alignment error (combinational).
- `data_req`  out  1  bus request.
- `data_wr`  out  1  1 = store.
- `data_size`  out  2  0 = byte, 1 = half, 2 = word.
- `data_addr`  out  32  bus address.
- `data_wdata`  out  32  replicated store data.
- `data_wstrb`  out  4  byte strobes; 0 for loads.
- `data_addr_ok`  in  1  request accepted.
- `data_data_ok`  in  1  response valid / store done.
- `data_rdata`  in  32  raw load word.
- `ls_stall_req`  out  1  hold EX.
- `mem_load_data`  out  32  extended load result.

## Operation
- Selector codes: NOP = 0, LB = 1, LBU = 2, LH = 3, LHU = 4, LW = 5, SB = 6, SH = 7, SW = 8. Other codes are treated as NOP.
- Address errors:
  - ADEL: LH/LHU with addr[0] set, or LW with addr[1:0] ≠ 0.
  - ADES: the same rules for SH and SW.
  - Both flags are gated by `ex_ls_ena`.
- An issue is eligible when `ex_ls_ena` is set, `ex_has_exception` is clear, neither address error is raised, `flush` is clear, and the selector is valid.
- Store data:
  - SB: `{4{rt[7:0]}}`, strobe `4'b0001 << addr[1:0]`.
  - SH: `{2{rt[15:0]}}`, strobe `4'b0011 << addr[1:0]`.
  - SW: `rt` unchanged, strobe `4'hF`.
- At issue, the block captures: selector, addr[1:0], and the latched request fields (`addr`, `size`, `wr`, `wdata`, `wstrb`).
- FSM:
  - **IDLE**:
    - `data_req` is driven combinationally from the eligible EX request.
    - With `addr_ok` → DATA. Without it → ADDR.
  - **ADDR**:
    - `data_req` stays asserted with the latched fields, which must be stable.
    - `addr_ok` → DATA, or → CANCEL if `flush` was seen while in ADDR.
  - **DATA**:
    - `data_ok` with no flush → DONE.
    - `flush` → CANCEL.
  - **DONE**:
    - Holds the result while `pipe_stall` is set.
    - Without `pipe_stall` → IDLE. A new eligible request may issue in the same cycle, with the IDLE rules.
  - **CANCEL**:
    - Waits for the outstanding `data_ok`, discards it and leaves `mem_load_data` unchanged.
    - Then → IDLE.
    - No new issue is allowed while in CANCEL.
- A flush seen in ADDR is remembered in a sticky bit. The request is never withdrawn before `addr_ok`.
- Load extension on `data_ok`, selecting the byte or half with the latched addr[1:0]:
  - LB: sign-extend the selected byte. LBU: zero-extend it.
  - LH: sign-extend the selected half. LHU: zero-extend it.
  - LW: the word unchanged.
  - The result is registered into `mem_load_data`. Stores leave `mem_load_data` unchanged.
- `ls_stall_req` is asserted in any of these cases:
  - (IDLE with an eligible request) and no `data_ok` in the same cycle;
  - ADDR;
  - DATA and not `data_ok`;
  - CANCEL with `ex_ls_ena` set.

## Timing
- Reset values: state IDLE, `data_req` 0, `data_wr` 0, `data_size` 0, `data_addr` 0, `data_wdata` 0, `data_wstrb` 0, `ls_stall_req` 0, `mem_load_data` 0, flush-sticky 0.
- Reset mid-transaction returns to IDLE immediately. The bus side must also be reset.
- Best-case latency:
  - `addr_ok` in the issue cycle, `data_ok` one cycle later.
  - `ls_stall_req` is high for 1 cycle.
  - `mem_load_data` is valid on the edge after `data_ok` and is held until the next load's `data_ok`.
- At most one transaction is outstanding.
- `addr_ok` and `data_ok` in the same cycle as issue is not a legal bus behaviour. The FSM ignores `data_ok` in IDLE and ADDR.
- `flush` and `data_ok` in the same DATA cycle: flush wins → IDLE, and the data is discarded.
- The address-error flags are pure combinational from the EX inputs, with no state dependence.

## Structure
- Selector codes and FSM state encodings (IDLE = 0, ADDR = 1, DATA = 2, DONE = 3, CANCEL = 4) belong in the shared ID/definitions header alongside the existing ALU and source-select codes.
- One natural sub-module, `ls_data_fmt`: combinational store replication/strobe and load extraction/extension.

## Test plan
- **LW addr 0x1000**, `addr_ok` same cycle, `data_ok` next cycle with 0xDEADBEEF → `ls_stall_req` high for 1 cycle; `mem_load_data` = 0xDEADBEEF.
- **LB / LBU addr 0x1003**, `rdata` 0x80FF_FF_FF → LB gives 0xFFFFFF80; LBU gives 0x00000080.
- **SH addr 0x2002**, rt 0x1234ABCD → `wdata` 0xABCDABCD, `wstrb` 0b1100, `size` 1, `wr` 1.
- **LW addr 0x1002** → `to_ex_is_data_adel` = 1, no `data_req`. **SH addr 0x2001** → `ades` = 1.
- **LW with `addr_ok` delayed 3 cycles**, `flush` in the second cycle → `data_req` held stable until `addr_ok`; CANCEL absorbs `data_ok`; `mem_load_data` unchanged.
- **`rst` low asserted in DATA** → all outputs 0 asynchronously; after release the next LW completes normally.
